ldm_wb_seq: RTL and testbench
=============================

LDM_WB_SEQ -- requirements
Module: ldm_wb_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-003 The block SHALL have port en, input, 1 bit: pipeline enable; 0 freezes all state and deasserts o_mem_ready.
REQ-004 The block SHALL have port i_start, input, 1 bit: begin a load-multiple; sampled in IDLE only.
REQ-005 The block SHALL have port i_reg_list, input, 16 bits: bit n set means load rn.
REQ-006 The block SHALL have ports i_base_code (input, 4 bits) and i_base_reg (input, 32 bits): base register number and value.
REQ-007 The block SHALL have ports i_up, i_pre and i_wback, inputs, 1 bit each: increment/decrement, pre/post index, base writeback request.
REQ-008 The block SHALL have ports o_mem_addr (output, 32), o_mem_ready (output, 1), i_mem_valid (input, 1) and i_mem_data (input, 32): memory read beat handshake.
REQ-009 The block SHALL have ports o_rd_en_wb (output, 1), o_rd_code_wb (output, 4) and o_rd_reg_wb (output, 32): register file WB write port.
REQ-010 The block SHALL have ports o_rd_en_ex (output, 1), o_rd_code_ex (output, 4) and o_rd_reg_ex (output, 32): register file EX write port, carrying base writeback.
REQ-011 The block SHALL have ports o_busy (output, 1), high when state is not IDLE, and o_done (output, 1), a one-cycle completion pulse.

Function
REQ-012 The state machine SHALL have states IDLE, LOAD and DONE.
REQ-013 In IDLE, i_start=1 with en=1 SHALL latch all inputs, compute N as the popcount of i_reg_list, and go to LOAD; if N=0 it SHALL go to DONE.
REQ-014 The first address SHALL be: IA base; IB base+4; DA base-4N+4; DB base-4N (32-bit wrap-around, no overflow flag).
REQ-015 In LOAD, o_mem_ready SHALL be 1 and o_mem_addr valid; a beat is i_mem_valid & o_mem_ready & en.
REQ-016 Each beat SHALL clear the lowest set bit of the latched list and advance o_mem_addr by 4.
REQ-017 A beat SHALL raise o_rd_en_wb for exactly one cycle, in the next cycle, with o_rd_code_wb set to that lowest register number and o_rd_reg_wb set to i_mem_data; registers SHALL load in ascending order.
REQ-018 The cycle after the last beat SHALL be DONE, in which the last WB write is visible.
REQ-019 DONE SHALL assert o_done for one cycle and then return to IDLE; i_start in DONE SHALL be ignored.
REQ-020 Base writeback SHALL drive o_rd_en_ex=1 in DONE, with o_rd_code_ex equal to the base code and value base+4N (up) or base-4N (down).
REQ-021 Base writeback SHALL be suppressed if the base register is in the list (the loaded value wins) or if N=0.
REQ-022 A load of r15 SHALL be written like any register, through the WB port.
REQ-023 A mem-valid without ready SHALL be ignored.
REQ-024 With en=0, state, address, list and all outputs SHALL hold, except o_mem_ready=0.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL go to IDLE and drive every output to 0 (addresses, codes and data included), regardless of operation in progress.
REQ-026 An in-flight transfer aborted by reset SHALL produce no further writes and no o_done.

Configuration
REQ-027 With macro LDM_BASE_WB_EN defined, REQ-020/021 SHALL apply.
REQ-028 Without LDM_BASE_WB_EN, o_rd_en_ex, o_rd_code_ex and o_rd_reg_ex SHALL be tied to 0 and i_wback ignored.

Structure
REQ-029 A shared package SHALL hold REG_SP=13, REG_LR=14, REG_PC=15, the IDLE/LOAD/DONE state encoding, and WORD_BYTES=4.
REQ-030 Sub-module reg_list_penc SHALL be combinational and give the lowest-set-bit index, a valid flag, and popcount for a 16-bit list.

Verification
REQ-031 The bench SHALL cover: IA, list 0x000F, base r13=0x1000, wback, valid every cycle -> reads 0x1000..0x100C; r0..r3 written on 4 consecutive cycles; DONE EX write r13=0x1010.
REQ-032 The bench SHALL cover: DB, list 0x8001, base 0x2000 -> addresses 0x1FF8, 0x1FFC; r0 then r15 written; writeback 0x1FF8.
REQ-033 The bench SHALL cover: IA, list 0x0010 with base r4 in list, wback=1 -> r4 gets memory data; o_rd_en_ex stays 0.
REQ-034 The bench SHALL cover: empty list -> o_busy 1 cycle, o_done pulses, no WB or EX write.
REQ-035 The bench SHALL cover: i_mem_valid gaps plus en=0 for 3 cycles mid-transfer -> no duplicate or skipped writes; order preserved.
REQ-036 The bench SHALL cover: rst=1 after the 2nd beat of a 4-register load -> next cycle IDLE, all outputs 0, no further writes.

Source files
------------

// File: rtl/ldm_wb_seq_pkg.sv
// Shared constants, state encoding and address helpers for the load-multiple sequencer.
package ldm_wb_seq_pkg;

  localparam logic [3:0]  REG_SP     = 4'd13;
  localparam logic [3:0]  REG_LR     = 4'd14;
  localparam logic [3:0]  REG_PC     = 4'd15;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] span_bytes(input logic [4:0] n);
    return {25'd0, n, 2'b00};
  endfunction

  // Lowest address touched: IA base, IB base+4, DA base-4N+4, DB base-4N.
  function automatic logic [31:0] first_addr(input logic [31:0] base, input logic [4:0] n,
                                             input logic up, input logic pre);
    logic [31:0] a;
    if (up) a = pre ? base + WORD_BYTES : base;
    else    a = pre ? base - span_bytes(n) : base - span_bytes(n) + WORD_BYTES;
    return a;
  endfunction

  function automatic logic [31:0] wback_value(input logic [31:0] base, input logic [4:0] n,
                                              input logic up);
    return up ? base + span_bytes(n) : base - span_bytes(n);
  endfunction

endpackage

// File: rtl/ldm_wb_seq_reg_list_penc.sv
// Combinational priority encoder for a 16-bit register list: lowest set index,
// non-empty flag and population count.
module reg_list_penc (
  input  logic [15:0] i_list,
  output logic [3:0]  o_idx,
  output logic        o_valid,
  output logic [4:0]  o_count
);

  assign o_valid = |i_list;

  always_comb begin
    o_idx   = 4'd0;
    o_count = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (i_list[i]) o_idx = i[3:0];
    end
    for (int i = 0; i < 16; i++) begin
      o_count = o_count + {4'd0, i_list[i]};
    end
  end

endmodule

// File: rtl/ldm_wb_seq.sv
// Load-multiple sequencer: issues one memory read beat per listed register and
// writes results through the WB port. Optional base writeback under LDM_BASE_WB_EN.
module ldm_wb_seq
  import ldm_wb_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        i_start,
  input  logic [15:0] i_reg_list,
  input  logic [3:0]  i_base_code,
  input  logic [31:0] i_base_reg,
  input  logic        i_up,
  input  logic        i_pre,
  input  logic        i_wback,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_data,
  output logic        o_rd_en_wb,
  output logic [3:0]  o_rd_code_wb,
  output logic [31:0] o_rd_reg_wb,
  output logic        o_rd_en_ex,
  output logic [3:0]  o_rd_code_ex,
  output logic [31:0] o_rd_reg_ex,
  output logic        o_busy,
  output logic        o_done
);

  state_t      r_state, w_state_next;
  logic [31:0] r_addr;
  logic [15:0] r_list;
  logic        r_rd_en_wb;
  logic [3:0]  r_rd_code_wb;
  logic [31:0] r_rd_reg_wb;

  logic [15:0] w_penc_in;
  logic [3:0]  w_idx;
  logic        w_valid;
  logic [4:0]  w_count;
  logic        w_start;
  logic        w_beat;
  logic        w_last;

  // In IDLE the encoder sizes the incoming list; afterwards it walks the latched one.
  assign w_penc_in = (r_state == ST_IDLE) ? i_reg_list : r_list;

  reg_list_penc u_penc (
    .i_list  (w_penc_in),
    .o_idx   (w_idx),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign w_start = (r_state == ST_IDLE) & i_start & en;
  assign w_beat  = (r_state == ST_LOAD) & i_mem_valid & en;
  assign w_last  = (w_count == 5'd1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_next = w_valid ? ST_LOAD : ST_DONE;
      ST_LOAD: if (w_beat && w_last) w_state_next = ST_DONE;
      ST_DONE: if (en) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= 32'd0;
      r_list       <= 16'd0;
      r_rd_en_wb   <= 1'b0;
      r_rd_code_wb <= 4'd0;
      r_rd_reg_wb  <= 32'd0;
    end else if (en) begin
      r_rd_en_wb <= 1'b0;
      if (w_start) begin
        r_list <= i_reg_list;
        r_addr <= first_addr(i_base_reg, w_count, i_up, i_pre);
      end
      if (w_beat) begin
        r_list       <= r_list & (r_list - 16'd1);
        r_addr       <= r_addr + WORD_BYTES;
        r_rd_en_wb   <= 1'b1;
        r_rd_code_wb <= w_idx;
        r_rd_reg_wb  <= i_mem_data;
      end
    end
  end

  assign o_mem_addr   = r_addr;
  assign o_mem_ready  = (r_state == ST_LOAD) & en;
  assign o_rd_en_wb   = r_rd_en_wb;
  assign o_rd_code_wb = r_rd_code_wb;
  assign o_rd_reg_wb  = r_rd_reg_wb;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_DONE);

`ifdef LDM_BASE_WB_EN
  logic        r_ex_en;
  logic [3:0]  r_ex_code;
  logic [31:0] r_ex_val;

  // A listed base register takes the loaded value, so writeback is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_en   <= 1'b0;
      r_ex_code <= 4'd0;
      r_ex_val  <= 32'd0;
    end else if (w_start) begin
      r_ex_en   <= i_wback & w_valid & ~i_reg_list[i_base_code];
      r_ex_code <= i_base_code;
      r_ex_val  <= wback_value(i_base_reg, w_count, i_up);
    end
  end

  assign o_rd_en_ex   = r_ex_en & (r_state == ST_DONE);
  assign o_rd_code_ex = o_rd_en_ex ? r_ex_code : 4'd0;
  assign o_rd_reg_ex  = o_rd_en_ex ? r_ex_val : 32'd0;
`else
  logic w_unused;
  assign w_unused     = ^{i_wback, i_base_code};
  assign o_rd_en_ex   = 1'b0;
  assign o_rd_code_ex = 4'd0;
  assign o_rd_reg_ex  = 32'd0;
`endif

endmodule

// File: tb/tb_ldm_wb_seq.sv
// Directed and randomized bench for ldm_wb_seq against a list/queue reference model.
module tb_ldm_wb_seq;

`ifdef LDM_BASE_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, i_start, i_up, i_pre, i_wback, i_mem_valid;
  logic [15:0] i_reg_list;
  logic [3:0]  i_base_code;
  logic [31:0] i_base_reg, i_mem_data;
  logic [31:0] o_mem_addr, o_rd_reg_wb, o_rd_reg_ex;
  logic        o_mem_ready, o_rd_en_wb, o_rd_en_ex, o_busy, o_done;
  logic [3:0]  o_rd_code_wb, o_rd_code_ex;

  ldm_wb_seq dut (
    .clk(clk), .rst(rst), .en(en), .i_start(i_start), .i_reg_list(i_reg_list),
    .i_base_code(i_base_code), .i_base_reg(i_base_reg), .i_up(i_up), .i_pre(i_pre),
    .i_wback(i_wback), .o_mem_addr(o_mem_addr), .o_mem_ready(o_mem_ready),
    .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data), .o_rd_en_wb(o_rd_en_wb),
    .o_rd_code_wb(o_rd_code_wb), .o_rd_reg_wb(o_rd_reg_wb), .o_rd_en_ex(o_rd_en_ex),
    .o_rd_code_ex(o_rd_code_ex), .o_rd_reg_ex(o_rd_reg_ex), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] cur_salt = 32'd0;

  // Observed traffic; a write or pulse only counts in a cycle where en lets it commit.
  logic [3:0]  wb_code_q[$];
  logic [31:0] wb_data_q[$];
  int          wb_cyc_q[$];
  logic [3:0]  ex_code_q[$];
  logic [31:0] ex_val_q[$];
  logic [31:0] addr_q[$];
  int          done_cnt = 0;
  int          busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_rd_en_wb && en) begin
      wb_code_q.push_back(o_rd_code_wb);
      wb_data_q.push_back(o_rd_reg_wb);
      wb_cyc_q.push_back(cyc);
    end
    if (o_rd_en_ex && en) begin
      ex_code_q.push_back(o_rd_code_ex);
      ex_val_q.push_back(o_rd_reg_ex);
    end
    if (o_mem_ready && i_mem_valid) addr_q.push_back(o_mem_addr);
    if (o_done && en) done_cnt <= done_cnt + 1;
    if (o_busy && en) busy_cnt <= busy_cnt + 1;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ cur_salt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_addr"},    o_mem_addr, 32'd0);
    check({pfx, "_ready"},   {31'd0, o_mem_ready}, 32'd0);
    check({pfx, "_wb_en"},   {31'd0, o_rd_en_wb}, 32'd0);
    check({pfx, "_wb_code"}, {28'd0, o_rd_code_wb}, 32'd0);
    check({pfx, "_wb_reg"},  o_rd_reg_wb, 32'd0);
    check({pfx, "_ex_en"},   {31'd0, o_rd_en_ex}, 32'd0);
    check({pfx, "_ex_code"}, {28'd0, o_rd_code_ex}, 32'd0);
    check({pfx, "_ex_reg"},  o_rd_reg_ex, 32'd0);
    check({pfx, "_busy"},    {31'd0, o_busy}, 32'd0);
    check({pfx, "_done"},    {31'd0, o_done}, 32'd0);
  endtask

  task automatic run_txn(input logic [15:0] list, input logic [3:0] bcode, input logic [31:0] base,
                         input logic up, input logic pre, input logic wb,
                         input bit gaps, input bit stall, input bit full_rate);
    int n, got, wb0, ex0, a0, d0, b0, gota;
    bit fin, exp_ex;
    logic [31:0] first, span;
    logic [3:0] regs[$];
    n = 0;
    for (int i = 0; i < 16; i++) if (list[i]) begin n++; regs.push_back(4'(i)); end
    span  = 32'(n) * 32'd4;
    first = up ? (pre ? base + 32'd4 : base) : (pre ? base - span : base - span + 32'd4);
    cur_salt = $urandom;
    wb0 = wb_code_q.size(); ex0 = ex_code_q.size(); a0 = addr_q.size();
    d0 = done_cnt; b0 = busy_cnt;

    @(posedge clk); #1;
    en = 1'b1; i_start = 1'b1; i_reg_list = list; i_base_code = bcode; i_base_reg = base;
    i_up = up; i_pre = pre; i_wback = wb; i_mem_valid = 1'b0;
    @(posedge clk); #1;
    // Scramble the command inputs: the sequencer must run on what it latched.
    i_reg_list = ~list; i_base_reg = $urandom; i_up = ~up; i_pre = ~pre; i_base_code = ~bcode;
    fin = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      i_start     = 1'($urandom_range(0, 1));
      en          = !(stall && c >= 3 && c < 6);
      i_mem_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_mem_data  = memf(o_mem_addr);
      @(posedge clk); #1;
      if (!o_busy) fin = 1'b1;
    end
    i_start = 1'b0; i_mem_valid = 1'b0; en = 1'b1;
    check("timeout", {31'd0, fin}, 32'd1);

    got = wb_code_q.size() - wb0;
    check("wb_count", 32'(got), 32'(n));
    for (int k = 0; k < n && k < got; k++) begin
      check("wb_code", {28'd0, wb_code_q[wb0 + k]}, {28'd0, regs[k]});
      check("wb_data", wb_data_q[wb0 + k], memf(first + 32'(k) * 32'd4));
    end
    gota = addr_q.size() - a0;
    check("beat_count", 32'(gota), 32'(n));
    for (int k = 0; k < n && k < gota; k++)
      check("mem_addr", addr_q[a0 + k], first + 32'(k) * 32'd4);
    if (full_rate) begin
      check("busy_cycles", 32'(busy_cnt - b0), 32'(n + 1));
      for (int k = 1; k < n && k < got; k++)
        check("wb_consecutive", 32'(wb_cyc_q[wb0 + k] - wb_cyc_q[wb0 + k - 1]), 32'd1);
    end
    exp_ex = WB_EN && wb && (n > 0) && !list[bcode];
    check("ex_count", 32'(ex_code_q.size() - ex0), {31'd0, exp_ex});
    if (exp_ex && ex_code_q.size() > ex0) begin
      check("ex_code", {28'd0, ex_code_q[ex0]}, {28'd0, bcode});
      check("ex_value", ex_val_q[ex0], up ? base + span : base - span);
    end
    check("done_pulse", 32'(done_cnt - d0), 32'd1);
    $display("txn list=%04h base=%08h code=%0d up=%0d pre=%0d wb=%0d n=%0d first=%08h writes=%0d ex=%0d",
             list, base, bcode, up, pre, wb, n, first, got, ex_code_q.size() - ex0);
  endtask

  initial begin
    int wb0, d0, ex0;
    rst = 1'b1; en = 1'b1; i_start = 1'b0; i_reg_list = 16'd0; i_base_code = 4'd0;
    i_base_reg = 32'd0; i_up = 1'b0; i_pre = 1'b0; i_wback = 1'b0;
    i_mem_valid = 1'b0; i_mem_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    run_txn(16'h000F, 4'd13, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // IA
    run_txn(16'h8001, 4'd13, 32'h0000_2000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); // DB
    run_txn(16'h0010, 4'd4,  32'h0000_3000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // base in list
    run_txn(16'h0000, 4'd13, 32'h0000_5000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // empty
    run_txn(16'h5A3C, 4'd2,  32'h0000_4000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // gaps + stall
    run_txn(16'h00FF, 4'd9,  32'h0000_0004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // DA wrap
    run_txn(16'hFFFF, 4'd15, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); // IB wrap, all regs

    // Reset after the second beat of a four-register load.
    cur_salt = $urandom;
    wb0 = wb_code_q.size(); d0 = done_cnt; ex0 = ex_code_q.size();
    @(posedge clk); #1;
    i_start = 1'b1; i_reg_list = 16'h000F; i_base_code = 4'd13; i_base_reg = 32'h0000_1000;
    i_up = 1'b1; i_pre = 1'b0; i_wback = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_mem_valid = 1'b1; i_mem_data = memf(o_mem_addr);
    @(posedge clk); #1;
    i_mem_data = memf(o_mem_addr);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("abort");
    repeat (5) @(posedge clk);
    #1;
    i_mem_valid = 1'b0;
    check("abort_writes", 32'(wb_code_q.size() - wb0), 32'd2);
    if (wb_code_q.size() - wb0 == 2) begin
      check("abort_code0", {28'd0, wb_code_q[wb0]}, 32'd0);
      check("abort_code1", {28'd0, wb_code_q[wb0 + 1]}, 32'd1);
      check("abort_data1", wb_data_q[wb0 + 1], memf(32'h0000_1004));
    end
    check("abort_done", 32'(done_cnt - d0), 32'd0);
    check("abort_ex", 32'(ex_code_q.size() - ex0), 32'd0);
    $display("txn reset-abort writes=%0d done=%0d", wb_code_q.size() - wb0, done_cnt - d0);

    for (int t = 0; t < 16; t++) begin
      run_txn(16'($urandom), 4'($urandom), $urandom & 32'hFFFF_FFFC,
              1'($urandom), 1'($urandom), 1'($urandom),
              1'b1, 1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
